// File: rtl/qec_sequencer_pkg.sv
// Shared types and constants for the decode round sequencer: FSM state encoding,
// result status codes and the deadlock guard window.
package qec_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_START  = 2'd1,
        SEQ_RUN    = 2'd2,
        SEQ_OUTPUT = 2'd3
    } seq_state_t;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_DEADLOCK = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

    // Deadlock flags are ignored while the RUN cycle count is at or below this.
    localparam int unsigned DEADLOCK_GUARD_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/round_watchdog_counter.sv
// 32-bit saturating round cycle counter. Clear and enable together load 1, so the
// first counted cycle after a clear reads 1; expired flags the last allowed cycle.
module round_watchdog_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        en_i,
    output logic [31:0] count_o,
    output logic        expired_o
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] count_inc;

    assign count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = en_i ? 32'd1 : 32'd0;
        end else if (en_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/decode_round_sequencer.sv
// Round-level controller for one left/right decoder pair: accepts a syndrome frame,
// pulses new_round_start, waits for both halves (or deadlock/timeout) and returns results.
module decode_round_sequencer
    import qec_sequencer_pkg::*;
#(
    parameter int unsigned CODE_DISTANCE_X         = 5,
    parameter int unsigned CODE_DISTANCE_Z         = 4,
    parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES          = 4096,
    localparam int unsigned MEASUREMENT_ROUNDS     = max_u(CODE_DISTANCE_X, CODE_DISTANCE_Z),
    localparam int unsigned PU_COUNT               = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    localparam int unsigned ADDRESS_WIDTH          = 3 * $clog2(MEASUREMENT_ROUNDS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PU_COUNT-1:0]                   syndrome_in_data,
    input  logic                                  syndrome_in_valid,
    output logic                                  syndrome_in_ready,
    output logic [PU_COUNT-1:0]                   is_error_syndromes,
    output logic                                  new_round_start,
    input  logic                                  left_result_valid,
    input  logic                                  right_result_valid,
    input  logic                                  left_deadlock,
    input  logic                                  right_deadlock,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]     net_roots,
    input  logic [ITERATION_COUNTER_WIDTH-1:0]    left_iteration_counter,
    output logic [ADDRESS_WIDTH*PU_COUNT-1:0]     result_roots,
    output logic [ITERATION_COUNTER_WIDTH-1:0]    result_iterations,
    output logic [31:0]                           result_cycles,
    output logic [1:0]                            result_status,
    output logic [15:0]                           result_round_id,
    output logic                                  result_valid,
    input  logic                                  result_ready
);

    seq_state_t                             state_q;
    logic                                   ready_q;
    logic                                   start_q;
    logic                                   result_valid_q;
    logic [PU_COUNT-1:0]                    syndromes_q;
    logic [15:0]                            round_id_q;
    logic [15:0]                            result_round_id_q;
    logic [ADDRESS_WIDTH*PU_COUNT-1:0]      result_roots_q;
    logic [ITERATION_COUNTER_WIDTH-1:0]     result_iterations_q;
    logic [31:0]                            result_cycles_q;
    logic [1:0]                             result_status_q;
    logic                                   left_done_q;
    logic                                   right_done_q;
    logic                                   prev_left_q;
    logic                                   prev_right_q;

    logic [31:0] cycle_count;
    logic        watchdog_expired;
    logic        counter_clear;
    logic        counter_en;
    logic        left_rise;
    logic        right_rise;
    logic        deadlock_seen;
    logic        both_done;
    logic        exit_now;
    logic [1:0]  exit_status;

    assign counter_clear = (state_q == SEQ_START);
    assign counter_en    = (state_q == SEQ_START) || (state_q == SEQ_RUN);

    round_watchdog_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (counter_clear),
        .en_i     (counter_en),
        .count_o  (cycle_count),
        .expired_o(watchdog_expired)
    );

    // History is sampled every cycle, so a level still high from the previous
    // round (including through START) never looks like a fresh completion.
    assign left_rise     = left_result_valid & ~prev_left_q;
    assign right_rise    = right_result_valid & ~prev_right_q;
    assign deadlock_seen = (left_deadlock | right_deadlock)
                           && (cycle_count > 32'(DEADLOCK_GUARD_CYCLES));
    assign both_done     = (left_done_q | left_rise) & (right_done_q | right_rise);

    always_comb begin
        exit_now    = 1'b1;
        exit_status = STATUS_OK;
        if (deadlock_seen) begin
            exit_status = STATUS_DEADLOCK;
        end else if (both_done) begin
            exit_status = STATUS_OK;
        end else if (watchdog_expired) begin
            exit_status = STATUS_TIMEOUT;
        end else begin
            exit_now = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= SEQ_IDLE;
            ready_q             <= 1'b0;
            start_q             <= 1'b0;
            result_valid_q      <= 1'b0;
            syndromes_q         <= '0;
            round_id_q          <= 16'd0;
            result_round_id_q   <= 16'd0;
            result_roots_q      <= '0;
            result_iterations_q <= '0;
            result_cycles_q     <= 32'd0;
            result_status_q     <= STATUS_OK;
            left_done_q         <= 1'b0;
            right_done_q        <= 1'b0;
            prev_left_q         <= 1'b0;
            prev_right_q        <= 1'b0;
        end else begin
            prev_left_q  <= left_result_valid;
            prev_right_q <= right_result_valid;
            start_q      <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (syndrome_in_valid && ready_q) begin
                        syndromes_q <= syndrome_in_data;
                        round_id_q  <= round_id_q + 16'd1;
                        ready_q     <= 1'b0;
                        start_q     <= 1'b1;
                        state_q     <= SEQ_START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SEQ_START: begin
                    left_done_q  <= 1'b0;
                    right_done_q <= 1'b0;
                    state_q      <= SEQ_RUN;
                end
                SEQ_RUN: begin
                    left_done_q  <= left_done_q | left_rise;
                    right_done_q <= right_done_q | right_rise;
                    if (exit_now) begin
                        result_roots_q      <= net_roots;
                        result_iterations_q <= left_iteration_counter;
                        result_cycles_q     <= cycle_count;
                        result_status_q     <= exit_status;
                        result_round_id_q   <= round_id_q;
                        result_valid_q      <= 1'b1;
                        state_q             <= SEQ_OUTPUT;
                    end
                end
                SEQ_OUTPUT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        ready_q        <= 1'b1;
                        state_q        <= SEQ_IDLE;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign syndrome_in_ready  = ready_q;
    assign is_error_syndromes = syndromes_q;
    assign new_round_start    = start_q;
    assign result_roots       = result_roots_q;
    assign result_iterations  = result_iterations_q;
    assign result_cycles      = result_cycles_q;
    assign result_status      = result_status_q;
    assign result_round_id    = result_round_id_q;
    assign result_valid       = result_valid_q;

endmodule

// File: tb/tb_decode_round_sequencer.sv
// Directed bench for decode_round_sequencer: one task per scenario, inline checks,
// single summary line at the end.
module tb_decode_round_sequencer;

    localparam int PU = 100;
    localparam int AW = 9;
    localparam int IW = 8;
    localparam int RW = AW * PU;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PU-1:0] syndrome_in_data = '0;
    logic          syndrome_in_valid = 1'b0;
    logic          syndrome_in_ready;
    logic [PU-1:0] is_error_syndromes;
    logic          new_round_start;
    logic          left_result_valid = 1'b0;
    logic          right_result_valid = 1'b0;
    logic          left_deadlock = 1'b0;
    logic          right_deadlock = 1'b0;
    logic [RW-1:0] net_roots = '0;
    logic [IW-1:0] left_iteration_counter = '0;
    logic [RW-1:0] result_roots;
    logic [IW-1:0] result_iterations;
    logic [31:0]   result_cycles;
    logic [1:0]    result_status;
    logic [15:0]   result_round_id;
    logic          result_valid;
    logic          result_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_round_sequencer #(
        .CODE_DISTANCE_X(5),
        .CODE_DISTANCE_Z(4),
        .ITERATION_COUNTER_WIDTH(IW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .syndrome_in_data      (syndrome_in_data),
        .syndrome_in_valid     (syndrome_in_valid),
        .syndrome_in_ready     (syndrome_in_ready),
        .is_error_syndromes    (is_error_syndromes),
        .new_round_start       (new_round_start),
        .left_result_valid     (left_result_valid),
        .right_result_valid    (right_result_valid),
        .left_deadlock         (left_deadlock),
        .right_deadlock        (right_deadlock),
        .net_roots             (net_roots),
        .left_iteration_counter(left_iteration_counter),
        .result_roots          (result_roots),
        .result_iterations     (result_iterations),
        .result_cycles         (result_cycles),
        .result_status         (result_status),
        .result_round_id       (result_round_id),
        .result_valid          (result_valid),
        .result_ready          (result_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] make_roots(input int seed);
        logic [RW-1:0] r;
        for (int i = 0; i < RW; i++) r[i] = (((i * seed) + (i / 3)) % 5) == 1;
        return r;
    endfunction

    // Presents a frame and returns in the cycle after acceptance (cycle N+1).
    task automatic send_frame(input logic [PU-1:0] f);
        int n;
        n = 0;
        syndrome_in_data  = f;
        syndrome_in_valid = 1'b1;
        while (syndrome_in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_wait: ready not seen after %0d cycles, required within 50", n);
        end
        tick();
        syndrome_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (syndrome_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", syndrome_in_ready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", result_valid); end
        checks++; if (new_round_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b want 0", new_round_start); end
        checks++; if (is_error_syndromes !== '0) begin errors++; $display("FAIL rst_syn: got %h want 0", is_error_syndromes); end
        checks++; if (result_cycles !== 32'd0 || result_status !== 2'b00 || result_round_id !== 16'd0) begin
            errors++; $display("FAIL rst_fields: got cyc=%0d st=%0d id=%0d want 0/0/0", result_cycles, result_status, result_round_id); end
        reset = 1'b1;
        checks++; if (syndrome_in_ready !== 1'b0) begin errors++; $display("FAIL rel_ready0: got %0b want 0", syndrome_in_ready); end
        tick();
        checks++; if (syndrome_in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready1: got %0b want 1", syndrome_in_ready); end
    endtask

    task automatic test_basic_ok;
        logic [PU-1:0] f;
        logic [RW-1:0] roots;
        f = '0;
        f[3] = 1'b1;
        roots = make_roots(7);
        net_roots = roots;
        left_iteration_counter = 8'h2A;
        left_result_valid = 1'b0;
        right_result_valid = 1'b0;
        send_frame(f);
        checks++; if (new_round_start !== 1'b1) begin errors++; $display("FAIL t1_start_n1: got %0b want 1", new_round_start); end
        checks++; if (is_error_syndromes !== f) begin errors++; $display("FAIL t1_syn: got %h want %h", is_error_syndromes, f); end
        tick();
        checks++; if (new_round_start !== 1'b0) begin errors++; $display("FAIL t1_start_n2: got %0b want 0", new_round_start); end
        for (int k = 1; k <= 12; k++) begin
            left_result_valid  = (k >= 10);
            right_result_valid = (k >= 12);
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: count %0d got %0b want 0", k, result_valid); end
            tick();
        end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %0b want 1", result_valid); end
        checks++; if (result_status !== 2'b00) begin errors++; $display("FAIL t1_status: got %0d want 0", result_status); end
        checks++; if (result_cycles !== 32'd12) begin errors++; $display("FAIL t1_cycles: got %0d want 12", result_cycles); end
        checks++; if (result_round_id !== 16'd1) begin errors++; $display("FAIL t1_round: got %0d want 1", result_round_id); end
        checks++; if (result_iterations !== 8'h2A) begin errors++; $display("FAIL t1_iter: got %h want 2a", result_iterations); end
        checks++; if (result_roots !== roots) begin errors++; $display("FAIL t1_roots: got %h want %h", result_roots, roots); end
        checks++; if (syndrome_in_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_out: got %0b want 0", syndrome_in_ready); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %0b want 0", result_valid); end
        checks++; if (syndrome_in_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_back: got %0b want 1", syndrome_in_ready); end
    endtask

    task automatic test_held_level;
        logic [PU-1:0] f;
        f = '0;
        f[0] = 1'b1;
        f[99] = 1'b1;
        left_iteration_counter = 8'h5C;
        right_result_valid = 1'b0;
        // left_result_valid is still high from the previous round
        send_frame(f);
        tick();
        for (int k = 1; k <= 7; k++) begin
            left_result_valid  = (k <= 2) || (k >= 7);
            right_result_valid = (k >= 5);
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t2_early_valid: count %0d got %0b want 0", k, result_valid); end
            tick();
        end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL t2_valid: got %0b want 1", result_valid); end
        checks++; if (result_cycles !== 32'd7) begin errors++; $display("FAIL t2_cycles: got %0d want 7", result_cycles); end
        checks++; if (result_status !== 2'b00) begin errors++; $display("FAIL t2_status: got %0d want 0", result_status); end
        checks++; if (result_round_id !== 16'd2 || result_iterations !== 8'h5C) begin
            errors++; $display("FAIL t2_id_iter: got id=%0d it=%h want 2/5c", result_round_id, result_iterations); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_timeout;
        left_result_valid = 1'b0;
        right_result_valid = 1'b0;
        send_frame(100'h5);
        tick();
        for (int k = 1; k <= 15; k++) begin
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t3_early_valid: count %0d got %0b want 0", k, result_valid); end
            tick();
        end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL t3_valid: got %0b want 1", result_valid); end
        checks++; if (result_status !== 2'b10) begin errors++; $display("FAIL t3_status: got %0d want 2", result_status); end
        checks++; if (result_cycles !== 32'd15) begin errors++; $display("FAIL t3_cycles: got %0d want 15", result_cycles); end
        checks++; if (result_round_id !== 16'd3) begin errors++; $display("FAIL t3_round: got %0d want 3", result_round_id); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_deadlock_guard;
        left_result_valid = 1'b0;
        right_result_valid = 1'b0;
        send_frame(100'h80);
        tick();
        for (int k = 1; k <= 4; k++) begin
            right_deadlock = (k == 1);
            if (k == 4) begin
                left_deadlock = 1'b1;
                left_result_valid = 1'b1;
                right_result_valid = 1'b1;
            end
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t4_early_valid: count %0d got %0b want 0", k, result_valid); end
            tick();
        end
        left_deadlock = 1'b0;
        right_deadlock = 1'b0;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %0b want 1", result_valid); end
        checks++; if (result_status !== 2'b01) begin errors++; $display("FAIL t4_status: got %0d want 1", result_status); end
        checks++; if (result_cycles !== 32'd4) begin errors++; $display("FAIL t4_cycles: got %0d want 4", result_cycles); end
        checks++; if (result_round_id !== 16'd4) begin errors++; $display("FAIL t4_round: got %0d want 4", result_round_id); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [PU-1:0] f5;
        logic [PU-1:0] f6;
        logic [RW-1:0] roots;
        f5 = 100'hABC;
        f6 = 100'h123;
        roots = make_roots(11);
        net_roots = roots;
        left_iteration_counter = 8'h31;
        left_result_valid = 1'b0;
        right_result_valid = 1'b0;
        send_frame(f5);
        tick();
        for (int k = 1; k <= 3; k++) begin
            left_result_valid  = (k >= 3);
            right_result_valid = (k >= 3);
            tick();
        end
        checks++; if (result_valid !== 1'b1 || result_cycles !== 32'd3) begin
            errors++; $display("FAIL t5_result: got v=%0b cyc=%0d want 1/3", result_valid, result_cycles); end
        net_roots = make_roots(13);
        left_iteration_counter = 8'h77;
        syndrome_in_data = f6;
        syndrome_in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++; if (result_valid !== 1'b1 || syndrome_in_ready !== 1'b0) begin
                errors++; $display("FAIL t5_hold_hs: cycle %0d got v=%0b rdy=%0b want 1/0", c, result_valid, syndrome_in_ready); end
            checks++; if (result_cycles !== 32'd3 || result_status !== 2'b00 || result_round_id !== 16'd5 || result_iterations !== 8'h31) begin
                errors++; $display("FAIL t5_hold_fields: cycle %0d got cyc=%0d st=%0d id=%0d it=%h want 3/0/5/31",
                                   c, result_cycles, result_status, result_round_id, result_iterations); end
            checks++; if (result_roots !== roots) begin errors++; $display("FAIL t5_hold_roots: got %h want %h", result_roots, roots); end
            checks++; if (is_error_syndromes !== f5) begin errors++; $display("FAIL t5_hold_syn: got %h want %h", is_error_syndromes, f5); end
            tick();
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++; if (syndrome_in_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL t5_after_hs: got rdy=%0b v=%0b want 1/0", syndrome_in_ready, result_valid); end
        tick();
        syndrome_in_valid = 1'b0;
        checks++; if (new_round_start !== 1'b1) begin errors++; $display("FAIL t5_next_start: got %0b want 1", new_round_start); end
        checks++; if (is_error_syndromes !== f6) begin errors++; $display("FAIL t5_next_syn: got %h want %h", is_error_syndromes, f6); end
        tick();
        // Round 6 is left running with completion levels held high (no edges).
        for (int k = 1; k <= 4; k++) tick();
    endtask

    task automatic test_reset_mid_round;
        reset = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || syndrome_in_ready !== 1'b0 || new_round_start !== 1'b0) begin
            errors++; $display("FAIL t6_rst_hs: got v=%0b rdy=%0b st=%0b want 0/0/0", result_valid, syndrome_in_ready, new_round_start); end
        checks++; if (is_error_syndromes !== '0 || result_roots !== '0) begin
            errors++; $display("FAIL t6_rst_data: got syn=%h want 0", is_error_syndromes); end
        checks++; if (result_cycles !== 32'd0 || result_round_id !== 16'd0 || result_iterations !== '0) begin
            errors++; $display("FAIL t6_rst_fields: got cyc=%0d id=%0d it=%h want 0/0/0", result_cycles, result_round_id, result_iterations); end
        tick();
        tick();
        reset = 1'b1;
        left_result_valid = 1'b0;
        right_result_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL t6_no_result: cycle %0d got %0b want 0", c, result_valid); end
            tick();
        end
        send_frame(100'h9);
        tick();
        for (int k = 1; k <= 2; k++) begin
            left_result_valid  = (k >= 2);
            right_result_valid = (k >= 2);
            tick();
        end
        checks++; if (result_valid !== 1'b1 || result_round_id !== 16'd1) begin
            errors++; $display("FAIL t6_round_id: got v=%0b id=%0d want 1/1", result_valid, result_round_id); end
        checks++; if (result_cycles !== 32'd2) begin errors++; $display("FAIL t6_cycles: got %0d want 2", result_cycles); end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_ok();
        test_held_level();
        test_timeout();
        test_deadlock_guard();
        test_backpressure();
        test_reset_mid_round();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
